fetch_unit: RTL and testbench

//   Instruction-fetch stage directly upstream of instmemory. Owns the program counter, drives the

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_loader.sv | 41 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch stage and its boot loader.
package fetch_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;
endpackage

// File: rtl/fetch_loader.sv
// Boot-loader write path: word counter and instmemory write-port drive while in LOAD.
module fetch_loader
   import fetch_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_active,
   input  logic        i_valid,
   input  logic        i_last,
   input  logic [31:0] i_data,
   output logic        o_ready,
   output logic        o_we,
   output logic [31:0] o_wreg,
   output logic [31:0] o_wdata,
   output logic        o_done
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] r_cnt;
   logic          w_accept;

   assign w_accept = i_active & i_valid;
   // The final slot ends the load even without load_last so the counter never wraps.
   assign o_done   = w_accept & (i_last | (r_cnt == AW'(DEPTH - 1)));
   assign o_ready  = i_active;
   assign o_we     = w_accept;
   assign o_wreg   = 32'(r_cnt);
   assign o_wdata  = i_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!i_active || o_done) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF pipeline registers and the IDLE/LOAD/RUN/ERR control FSM.
//   state | meaning
//   IDLE  | post-reset, decides between loading a program and running
//   LOAD  | streaming a program into instmemory through the loader
//   RUN   | fetching one instruction per unstalled cycle
//   ERR   | redirect went out of range; waits for reset or a new load
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int RESET_PC = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_start,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] imem_wreg,
   output logic [31:0] imem_wdata,
   output logic        imem_we,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        fault
);
   localparam int            AW     = $clog2(DEPTH);
   localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

   state_t        r_state;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_if_pc;
   logic [31:0]   r_if_instr;
   logic          r_if_valid;
   logic          r_fault;

   logic          w_loading;
   logic          w_load_done;
   logic          w_target_oob;
   logic [AW-1:0] w_pc_inc;

   assign w_loading    = (r_state == ST_LOAD);
   assign w_target_oob = (redirect_target >= 32'(DEPTH));
   assign w_pc_inc     = (r_pc == AW'(DEPTH - 1)) ? '0 : r_pc + 1'b1;

   fetch_loader #(.DEPTH(DEPTH)) u_loader (
      .clock    (clock),
      .reset    (reset),
      .i_active (w_loading),
      .i_valid  (load_valid),
      .i_last   (load_last),
      .i_data   (load_data),
      .o_ready  (load_ready),
      .o_we     (imem_we),
      .o_wreg   (imem_wreg),
      .o_wdata  (imem_wdata),
      .o_done   (w_load_done)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_pc       <= PC_RST;
         r_if_pc    <= '0;
         r_if_instr <= '0;
         r_if_valid <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= load_start ? ST_LOAD : ST_RUN;
            ST_LOAD: begin
               if (w_load_done) begin
                  r_state    <= ST_RUN;
                  r_pc       <= PC_RST;
                  r_if_valid <= 1'b0;
               end
            end
            ST_RUN: begin
               if (load_start) begin
                  r_state    <= ST_LOAD;
                  r_if_valid <= 1'b0;
               end else if (redirect) begin
                  // Redirect inserts a bubble even under stall; out-of-range targets park in ERR.
                  r_if_valid <= 1'b0;
                  if (w_target_oob) begin
                     r_state <= ST_ERR;
                     r_fault <= 1'b1;
                  end else begin
                     r_pc <= redirect_target[AW-1:0];
                  end
               end else if (!stall) begin
                  r_if_instr <= imem_instr;
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  r_pc       <= w_pc_inc;
               end
            end
            ST_ERR: begin
               if (load_start) begin
                  r_state <= ST_LOAD;
                  r_fault <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign imem_addr = 32'(r_pc);
   assign if_valid  = r_if_valid;
   assign if_instr  = r_if_instr;
   assign if_pc     = 32'(r_if_pc);
   assign fault     = r_fault;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instmemory attached to its ports.
module tb_fetch_unit;
   logic        clock = 1'b0;
   logic        reset;
   logic        load_start, load_valid, load_last;
   logic [31:0] load_data;
   logic        load_ready;
   logic [31:0] imem_addr, imem_instr, imem_wreg, imem_wdata;
   logic        imem_we;
   logic        stall, redirect;
   logic [31:0] redirect_target;
   logic        if_valid;
   logic [31:0] if_instr, if_pc;
   logic        fault;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [32];
   logic [31:0] prog [3];

   fetch_unit #(.DEPTH(32), .RESET_PC(0)) dut (
      .clock           (clock),
      .reset           (reset),
      .load_start      (load_start),
      .load_valid      (load_valid),
      .load_data       (load_data),
      .load_last       (load_last),
      .load_ready      (load_ready),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .imem_wreg       (imem_wreg),
      .imem_wdata      (imem_wdata),
      .imem_we         (imem_we),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .fault           (fault)
   );

   always #5 clock = ~clock;

   assign imem_instr = mem[imem_addr[4:0]];

   always @(posedge clock) begin
      if (imem_we) mem[imem_wreg[4:0]] = imem_wdata;
   end

   task automatic test_reset;
      reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
      stall = 0; redirect = 0; redirect_target = '0;
      repeat (2) @(negedge clock);
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
      n_cmp++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL rst_imem_addr: got %h want 0", imem_addr); end
      reset = 1'b0; load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL ld1_ready: got %b want 1", load_ready); end
      load_valid = 1'b1; load_data = 32'h1111_1111;
      @(negedge clock);
      n_cmp++; if (imem_wreg !== 32'd1) begin n_bad++; $display("FAIL ld1_wreg: got %0d want 1", imem_wreg); end
      load_data = 32'h2222_2222;
      @(negedge clock);
      load_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", load_ready); end
      n_cmp++; if (imem_wreg !== 32'd0) begin n_bad++; $display("FAIL midrst_cnt: got %0d want 0", imem_wreg); end
      @(negedge clock);
      n_cmp++; if (if_valid !== 1'b0 || fault !== 1'b0) begin n_bad++; $display("FAIL midrst_vf: got valid=%b fault=%b want 0 0", if_valid, fault); end
      n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: got ready=%b want 0", load_ready); end
   endtask

   task automatic test_load;
      prog[0] = 32'h00A2_00B3; prog[1] = 32'h4031_00B3; prog[2] = 32'h0062_E0B3;
      for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | i;
      reset = 1'b0; load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1; load_data = prog[i]; load_last = (i == 2);
         #1;
         n_cmp++; if (imem_we !== 1'b1 || imem_wreg !== i || imem_wdata !== prog[i]) begin
            n_bad++; $display("FAIL load_wr%0d: got we=%b wreg=%0d wdata=%h want 1 %0d %h", i, imem_we, imem_wreg, imem_wdata, i, prog[i]);
         end
         @(negedge clock);
      end
      load_valid = 1'b0; load_last = 1'b0;
      n_cmp++; if (load_ready !== 1'b0 || imem_we !== 1'b0) begin n_bad++; $display("FAIL load_exit: got ready=%b we=%b want 0 0", load_ready, imem_we); end
      n_cmp++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL load_pc: got %0d want 0", imem_addr); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         n_cmp++; if (if_instr !== prog[k] || if_pc !== k || if_valid !== 1'b1) begin
            n_bad++; $display("FAIL fetch%0d: got instr=%h pc=%0d v=%b want %h %0d 1", k, if_instr, if_pc, if_valid, prog[k], k);
         end
      end
   endtask

   task automatic test_stall;
      repeat (2) @(negedge clock);
      n_cmp++; if (imem_addr !== 32'd5 || if_pc !== 32'd4) begin n_bad++; $display("FAIL stall_pre: got addr=%0d pc=%0d want 5 4", imem_addr, if_pc); end
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         n_cmp++; if (if_pc !== 32'd4 || if_instr !== 32'hC0DE_0004 || imem_addr !== 32'd5 || if_valid !== 1'b1) begin
            n_bad++; $display("FAIL stall%0d: got pc=%0d instr=%h addr=%0d v=%b want 4 c0de0004 5 1", c, if_pc, if_instr, imem_addr, if_valid);
         end
      end
   endtask

   task automatic test_redirect_stall;
      redirect = 1'b1; redirect_target = 32'd10;
      @(negedge clock);
      n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd10) begin n_bad++; $display("FAIL redir_bubble: got v=%b addr=%0d want 0 10", if_valid, imem_addr); end
      redirect = 1'b0; stall = 1'b0;
      @(negedge clock);
      n_cmp++; if (if_pc !== 32'd10 || if_instr !== 32'hC0DE_000A || if_valid !== 1'b1) begin
         n_bad++; $display("FAIL redir_fetch: got pc=%0d instr=%h v=%b want 10 c0de000a 1", if_pc, if_instr, if_valid);
      end
   endtask

   task automatic test_wrap;
      redirect = 1'b1; redirect_target = 32'd31;
      @(negedge clock);
      redirect = 1'b0;
      n_cmp++; if (imem_addr !== 32'd31) begin n_bad++; $display("FAIL wrap_pre: got addr=%0d want 31", imem_addr); end
      @(negedge clock);
      n_cmp++; if (if_pc !== 32'd31 || if_instr !== 32'hC0DE_001F || imem_addr !== 32'd0) begin
         n_bad++; $display("FAIL wrap31: got pc=%0d instr=%h addr=%0d want 31 c0de001f 0", if_pc, if_instr, imem_addr);
      end
      @(negedge clock);
      n_cmp++; if (if_pc !== 32'd0 || if_instr !== 32'h00A2_00B3 || imem_addr !== 32'd1) begin
         n_bad++; $display("FAIL wrap0: got pc=%0d instr=%h addr=%0d want 0 00a200b3 1", if_pc, if_instr, imem_addr);
      end
   endtask

   task automatic test_fault;
      redirect = 1'b1; redirect_target = 32'd40;
      @(negedge clock);
      redirect = 1'b0;
      n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'd1) begin
         n_bad++; $display("FAIL fault_set: got f=%b v=%b addr=%0d want 1 0 1", fault, if_valid, imem_addr);
      end
      @(negedge clock);
      n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'd1) begin
         n_bad++; $display("FAIL fault_hold: got f=%b v=%b addr=%0d want 1 0 1", fault, if_valid, imem_addr);
      end
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      n_cmp++; if (fault !== 1'b0 || load_ready !== 1'b1) begin n_bad++; $display("FAIL fault_clear: got f=%b ready=%b want 0 1", fault, load_ready); end
   endtask

   task automatic test_full_load;
      for (int i = 0; i < 32; i++) begin
         load_valid = 1'b1; load_data = 32'hA500_0000 + i; load_last = 1'b0;
         #1;
         if (i == 31) begin
            n_cmp++; if (imem_wreg !== 32'd31 || imem_we !== 1'b1) begin n_bad++; $display("FAIL full_wreg: got %0d we=%b want 31 1", imem_wreg, imem_we); end
         end
         @(negedge clock);
      end
      load_valid = 1'b0;
      n_cmp++; if (load_ready !== 1'b0 || imem_addr !== 32'd0) begin n_bad++; $display("FAIL full_exit: got ready=%b addr=%0d want 0 0", load_ready, imem_addr); end
      @(negedge clock);
      n_cmp++; if (if_instr !== 32'hA500_0000 || if_pc !== 32'd0) begin n_bad++; $display("FAIL full_f0: got %h pc=%0d want a5000000 0", if_instr, if_pc); end
      @(negedge clock);
      n_cmp++; if (if_instr !== 32'hA500_0001 || if_pc !== 32'd1) begin n_bad++; $display("FAIL full_f1: got %h pc=%0d want a5000001 1", if_instr, if_pc); end
   endtask

   task automatic test_back_to_back;
      load_start = 1'b1; redirect = 1'b1; redirect_target = 32'd7;
      @(negedge clock);
      load_start = 1'b0; redirect = 1'b0;
      n_cmp++; if (load_ready !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL ls_beats_redir: got ready=%b v=%b want 1 0", load_ready, if_valid); end
      load_valid = 1'b1; load_data = 32'h00B0_0093; load_last = 1'b1;
      @(negedge clock);
      load_valid = 1'b0; load_last = 1'b0;
      n_cmp++; if (load_ready !== 1'b0 || imem_addr !== 32'd0) begin n_bad++; $display("FAIL b2b_exit: got ready=%b addr=%0d want 0 0", load_ready, imem_addr); end
      @(negedge clock);
      n_cmp++; if (if_instr !== 32'h00B0_0093 || if_pc !== 32'd0 || if_valid !== 1'b1) begin
         n_bad++; $display("FAIL b2b_fetch: got %h pc=%0d v=%b want 00b00093 0 1", if_instr, if_pc, if_valid);
      end
   endtask

   initial begin
      test_reset;
      test_load;
      test_stall;
      test_redirect_stall;
      test_wrap;
      test_fault;
      test_full_load;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
